display_scan: RTL and testbench

//   Read-side counterpart to the calculator operand/operator store.

---
 rtl/display_scan_if.sv | 27 ++
 rtl/display_scan.sv | 159 +++++++++++++++
 tb/tb_display_scan.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_scan_if : source operands and 7-segment pin bundle for       |
// |                   display_scan.                                      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface display_scan_if;
  logic [15:0] save1;
  logic [15:0] save2;
  logic [15:0] res;
  logic [1:0]  disp_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output save1, save2, res, disp_sel,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  save1, save2, res, disp_sel,
    output an, seg, dp, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_scan : per-frame snapshot of a 16-bit value, scanned as four |
// |                hex digits on a multiplexed active-low 7-seg display. |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module display_scan #(
  parameter int CLK_DIV  = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  display_scan_if.slave bus
);

  localparam int         PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] C_PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic          r_blank_all;
  logic          r_is_res;
  logic          r_first;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_boundary;
  logic [1:0]    w_idx_nx;
  logic [15:0]   w_src;
  logic [15:0]   w_shadow_nx;
  logic          w_blank_all_nx;
  logic          w_is_res_nx;
  logic [3:0]    w_nib;
  logic          w_lz;
  logic [6:0]    w_seg_code;
  logic [3:0]    w_an_nx;
  logic [6:0]    w_seg_nx;
  logic          w_dp_nx;

  assign w_tick = (r_presc == C_PMAX);
  // The first tick after reset opens a frame regardless of where idx sits.
  assign w_boundary = w_tick && ((r_idx == 2'd0) || r_first);

  always_comb begin
    w_src = 16'h0000;
    case (bus.disp_sel)
      2'b00:   w_src = bus.save1;
      2'b01:   w_src = bus.save2;
      2'b10:   w_src = bus.res;
      default: w_src = 16'h0000;
    endcase
  end

  always_comb begin
    w_idx_nx       = w_boundary ? 2'd3 : (r_idx - 2'd1);
    w_shadow_nx    = w_boundary ? w_src : r_shadow;
    w_blank_all_nx = w_boundary ? (bus.disp_sel == 2'b11) : r_blank_all;
    w_is_res_nx    = w_boundary ? (bus.disp_sel == 2'b10) : r_is_res;
  end

  // Digit selection and leading-zero test use the values being loaded on this tick.
  always_comb begin
    w_nib = 4'h0;
    w_lz  = 1'b0;
    case (w_idx_nx)
      2'd3: begin
        w_nib = w_shadow_nx[15:12];
        w_lz  = (w_shadow_nx[15:12] == 4'h0);
      end
      2'd2: begin
        w_nib = w_shadow_nx[11:8];
        w_lz  = (w_shadow_nx[15:8] == 8'h00);
      end
      2'd1: begin
        w_nib = w_shadow_nx[7:4];
        w_lz  = (w_shadow_nx[15:4] == 12'h000);
      end
      default: begin
        w_nib = w_shadow_nx[3:0];
        w_lz  = 1'b0;
      end
    endcase
    if (!BLANK_LZ) begin
      w_lz = 1'b0;
    end
  end

  always_comb begin
    w_seg_code = 7'h7F;
    case (w_nib)
      4'h0: w_seg_code = 7'b1000000;
      4'h1: w_seg_code = 7'b1111001;
      4'h2: w_seg_code = 7'b0100100;
      4'h3: w_seg_code = 7'b0110000;
      4'h4: w_seg_code = 7'b0011001;
      4'h5: w_seg_code = 7'b0010010;
      4'h6: w_seg_code = 7'b0000010;
      4'h7: w_seg_code = 7'b1111000;
      4'h8: w_seg_code = 7'b0000000;
      4'h9: w_seg_code = 7'b0010000;
      4'hA: w_seg_code = 7'b0001000;
      4'hB: w_seg_code = 7'b0000011;
      4'hC: w_seg_code = 7'b1000110;
      4'hD: w_seg_code = 7'b0100001;
      4'hE: w_seg_code = 7'b0000110;
      default: w_seg_code = 7'b0001110;
    endcase
  end

  always_comb begin
    w_an_nx  = ~(4'b0001 << w_idx_nx);
    w_seg_nx = w_seg_code;
    w_dp_nx  = ~(w_is_res_nx && (w_idx_nx == 2'd0));
    if (w_blank_all_nx || w_lz) begin
      w_an_nx  = 4'hF;
      w_seg_nx = 7'h7F;
      w_dp_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= 2'd3;
      r_shadow     <= 16'h0000;
      r_blank_all  <= 1'b1;
      r_is_res     <= 1'b0;
      r_first      <= 1'b1;
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : (r_presc + PW'(1));
      r_frame_done <= w_tick && (r_idx == 2'd0) && !r_first;
      if (w_tick) begin
        r_first     <= 1'b0;
        r_idx       <= w_idx_nx;
        r_shadow    <= w_shadow_nx;
        r_blank_all <= w_blank_all_nx;
        r_is_res    <= w_is_res_nx;
        r_an        <= w_an_nx;
        r_seg       <= w_seg_nx;
        r_dp        <= w_dp_nx;
      end
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_display_scan : directed self-checking bench for display_scan      |
// |                   with CLK_DIV=4.                                    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_display_scan;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   k;

  display_scan_if bus ();

  display_scan #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // k counts rising edges since reset release; sampling happens on the falling edge.
  task automatic adv(input int t);
    repeat (t - k) @(negedge clk);
    k = t;
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                          input logic dp_e, input logic fd_e);
    chk({tag, ".an"},  {4'h0, bus.an},          {4'h0, an_e});
    chk({tag, ".seg"}, {1'b0, bus.seg},         {1'b0, seg_e});
    chk({tag, ".dp"},  {7'h00, bus.dp},         {7'h00, dp_e});
    chk({tag, ".fd"},  {7'h00, bus.frame_done}, {7'h00, fd_e});
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    k            = 0;
    rst          = 1'b1;
    bus.save1    = 16'h0000;
    bus.save2    = 16'h0000;
    bus.res      = 16'h0000;
    bus.disp_sel = 2'b00;
    repeat (3) @(negedge clk);
    chk_pins("reset", 4'hF, 7'h7F, 1'b1, 1'b0);

    bus.save1    = 16'h1A3F;
    bus.disp_sel = 2'b00;
    rst          = 1'b0;
    adv(3);
    chk_pins("pre_first_tick", 4'hF, 7'h7F, 1'b1, 1'b0);
    adv(4);
    chk_pins("f1_d3", 4'h7, 7'b1111001, 1'b1, 1'b0);
    adv(7);
    chk("f1_d3_hold.an", {4'h0, bus.an}, 8'h07);
    adv(8);
    chk_pins("f1_d2", 4'hB, 7'b0001000, 1'b1, 1'b0);
    adv(12);
    chk_pins("f1_d1", 4'hD, 7'b0110000, 1'b1, 1'b0);
    adv(16);
    chk_pins("f1_d0", 4'hE, 7'b0001110, 1'b1, 1'b0);
    adv(20);
    chk_pins("f2_d3", 4'h7, 7'b1111001, 1'b1, 1'b1);
    adv(21);
    chk("fd_pulse_end", {7'h00, bus.frame_done}, 8'h00);

    bus.res      = 16'h0005;
    bus.disp_sel = 2'b10;
    adv(24);
    chk_pins("f2_d2_unchanged", 4'hB, 7'b0001000, 1'b1, 1'b0);
    adv(36);
    chk_pins("res_d3", 4'hF, 7'h7F, 1'b1, 1'b1);
    adv(40);
    chk_pins("res_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
    adv(44);
    chk_pins("res_d1", 4'hF, 7'h7F, 1'b1, 1'b0);
    adv(48);
    chk_pins("res_d0", 4'hE, 7'b0010010, 1'b0, 1'b0);

    bus.save2    = 16'h00A0;
    bus.disp_sel = 2'b01;
    adv(52);
    chk_pins("s2_d3", 4'hF, 7'h7F, 1'b1, 1'b1);
    adv(56);
    chk_pins("s2_d2", 4'hF, 7'h7F, 1'b1, 1'b0);
    adv(57);
    bus.save1    = 16'h8888;
    bus.disp_sel = 2'b00;
    adv(60);
    chk_pins("s2_d1", 4'hD, 7'b0001000, 1'b1, 1'b0);
    adv(64);
    chk_pins("s2_d0", 4'hE, 7'b1000000, 1'b1, 1'b0);
    adv(68);
    chk_pins("s1_d3", 4'h7, 7'b0000000, 1'b1, 1'b1);
    adv(72);
    chk_pins("s1_d2", 4'hB, 7'b0000000, 1'b1, 1'b0);

    adv(73);
    bus.disp_sel = 2'b11;
    adv(80);
    chk_pins("s1_d0", 4'hE, 7'b0000000, 1'b1, 1'b0);
    adv(84);
    chk_pins("off_d3", 4'hF, 7'h7F, 1'b1, 1'b1);
    adv(92);
    chk_pins("off_d1", 4'hF, 7'h7F, 1'b1, 1'b0);
    adv(96);
    chk_pins("off_d0", 4'hF, 7'h7F, 1'b1, 1'b0);
    adv(100);
    chk_pins("off_next", 4'hF, 7'h7F, 1'b1, 1'b1);

    adv(101);
    bus.disp_sel = 2'b00;
    adv(116);
    chk_pins("back_d3", 4'h7, 7'b0000000, 1'b1, 1'b1);
    adv(124);
    chk_pins("back_d1", 4'hD, 7'b0000000, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_pins("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k   = 0;
    adv(3);
    chk_pins("post_rst_wait", 4'hF, 7'h7F, 1'b1, 1'b0);
    adv(4);
    chk_pins("post_rst_d3", 4'h7, 7'b0000000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL timeout: observed running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
